// File: rtl/ft60x_bus_controller.sv
// FT600/FT601 245-synchronous-FIFO bus controller: bounded bursts, round-robin direction choice.
// Optional statistics counters are built when FT60X_STATS_EN is defined.
module ft60x_bus_controller #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BE_W       = DATA_W / 8,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usb_tx_full,
  input  logic              usb_rx_empty,
  output logic              usb_wren_l,
  output logic              usb_rden_l,
  output logic              usb_outen_l,
  output logic              usb_rst_l,
  output logic              ft601_data_bus_dir,
  input  logic [DATA_W-1:0] usb_data_in,
  input  logic [BE_W-1:0]   usb_be_in,
  output logic [DATA_W-1:0] usb_data_out,
  output logic [BE_W-1:0]   usb_be_out,
  input  logic [DATA_W-1:0] periph_data,
  input  logic              periph_data_available,
  output logic              read_periph_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [BE_W-1:0]   rx_be,
  output logic              rx_valid,
  input  logic              rx_afull
`ifdef FT60X_STATS_EN
  ,
  output logic [31:0]       stat_tx_words,
  output logic [31:0]       stat_rx_words,
  output logic [15:0]       stat_bursts
`endif
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    StReset, StIdle, StRdOe, StRdBurst, StRdEnd, StWrBurst, StTurn
  } state_e;

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
  logic              last_rd_q, last_rd_d;
  logic [DATA_W-1:0] rx_data_q;
  logic [BE_W-1:0]   rx_be_q;
  logic              rx_valid_q;

  logic rd_req, wr_req, wr_go, rd_cap, cnt_max;

  assign rd_req  = !usb_rx_empty && !rx_afull;
  assign wr_req  = periph_data_available && !usb_tx_full;
  assign cnt_max = (burst_cnt_q == CntW'(MAX_BURST));
  // A write burst that has hit its limit spends its exit cycle without writing.
  assign wr_go   = (state_q == StWrBurst) && wr_req && !cnt_max;
  assign rd_cap  = (state_q == StRdBurst) && !usb_rx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReset;
      rst_cnt_q   <= '0;
      burst_cnt_q <= '0;
      last_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      last_rd_q   <= last_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    burst_cnt_d = burst_cnt_q;
    last_rd_d   = last_rd_q;
    case (state_q)
      StReset: begin
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) state_d = StIdle;
        else rst_cnt_d = rst_cnt_q + RstW'(1);
      end
      StIdle: begin
        burst_cnt_d = '0;
        if (rd_req && (!wr_req || !last_rd_q)) begin
          state_d   = StRdOe;
          last_rd_d = 1'b1;
        end else if (wr_req) begin
          state_d   = StWrBurst;
          last_rd_d = 1'b0;
        end
      end
      StRdOe: state_d = StRdBurst;
      StRdBurst: begin
        if (rd_cap) burst_cnt_d = burst_cnt_q + CntW'(1);
        // Leave on the last word so rden_l never pulls a word we would drop.
        if (usb_rx_empty || rx_afull || (burst_cnt_d == CntW'(MAX_BURST))) state_d = StRdEnd;
      end
      StRdEnd: state_d = StTurn;
      StWrBurst: begin
        if (wr_go) burst_cnt_d = burst_cnt_q + CntW'(1);
        else state_d = StTurn;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    usb_wren_l         = 1'b1;
    usb_rden_l         = 1'b1;
    usb_outen_l        = 1'b1;
    ft601_data_bus_dir = 1'b0;
    read_periph_data   = 1'b0;
    case (state_q)
      StRdOe:    usb_outen_l = 1'b0;
      StRdBurst: begin
        usb_outen_l = 1'b0;
        usb_rden_l  = 1'b0;
      end
      StWrBurst: begin
        ft601_data_bus_dir = 1'b1;
        usb_wren_l         = !wr_go;
        read_periph_data   = wr_go;
      end
      default: ;
    endcase
  end

  assign usb_rst_l    = (state_q != StReset);
  assign usb_data_out = periph_data;
  assign usb_be_out   = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_be_q    <= '0;
    end else begin
      rx_valid_q <= rd_cap;
      if (rd_cap) begin
        rx_data_q <= usb_data_in;
        rx_be_q   <= usb_be_in;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_be    = rx_be_q;

`ifdef FT60X_STATS_EN
  logic [31:0] stat_tx_q, stat_rx_q;
  logic [15:0] stat_bursts_q;
  logic        burst_done;

  assign burst_done = (state_q != StTurn) && (state_d == StTurn);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tx_q     <= '0;
      stat_rx_q     <= '0;
      stat_bursts_q <= '0;
    end else begin
      stat_tx_q     <= stat_tx_q + 32'(wr_go);
      stat_rx_q     <= stat_rx_q + 32'(rd_cap);
      stat_bursts_q <= stat_bursts_q + 16'(burst_done);
    end
  end

  assign stat_tx_words = stat_tx_q;
  assign stat_rx_words = stat_rx_q;
  assign stat_bursts   = stat_bursts_q;
`endif

endmodule

// File: tb/tb_ft60x_bus_controller.sv
// Bench for ft60x_bus_controller: emulates the FT60x and arbiter FIFO, checks a phase model
// every cycle, plus directed scenarios with literal burst lengths and data order.
module tb_ft60x_bus_controller;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MB = 16;
  localparam int RC = 16;

  localparam int P_RESET = 0, P_IDLE = 1, P_RDOE = 2, P_RD = 3, P_RDEND = 4, P_WR = 5,
                 P_TURN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          usb_tx_full = 1'b0, usb_rx_empty = 1'b1, rx_afull = 1'b0;
  logic          periph_data_available = 1'b0;
  logic [DW-1:0] usb_data_in = '0, periph_data = '0;
  logic [BW-1:0] usb_be_in = '0;
  logic          usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l, ft601_data_bus_dir;
  logic          read_periph_data, rx_valid;
  logic [DW-1:0] usb_data_out, rx_data;
  logic [BW-1:0] usb_be_out, rx_be;
`ifdef FT60X_STATS_EN
  logic [31:0]   stat_tx_words, stat_rx_words;
  logic [15:0]   stat_bursts;
`endif

  ft60x_bus_controller #(
    .DATA_W(DW), .MAX_BURST(MB), .RST_CYCLES(RC)
  ) u_dut (
    .clk(clk), .rst(rst), .usb_tx_full(usb_tx_full), .usb_rx_empty(usb_rx_empty),
    .usb_wren_l(usb_wren_l), .usb_rden_l(usb_rden_l), .usb_outen_l(usb_outen_l),
    .usb_rst_l(usb_rst_l), .ft601_data_bus_dir(ft601_data_bus_dir),
    .usb_data_in(usb_data_in), .usb_be_in(usb_be_in), .usb_data_out(usb_data_out),
    .usb_be_out(usb_be_out), .periph_data(periph_data),
    .periph_data_available(periph_data_available), .read_periph_data(read_periph_data),
    .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_afull(rx_afull)
`ifdef FT60X_STATS_EN
    , .stat_tx_words(stat_tx_words), .stat_rx_words(stat_rx_words), .stat_bursts(stat_bursts)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment: FT60x RX FIFO contents and arbiter FIFO contents.
  typedef struct packed {logic [DW-1:0] d; logic [BW-1:0] be;} rx_word_t;
  rx_word_t      rxq[$];
  logic [DW-1:0] txq[$];
  logic [DW-1:0] exp_txq[$];
  int full_pct = 0, stall_pct = 0, afull_pct = 0, gap_pct = 0;
  bit force_full = 1'b0;

  task automatic push_tx(input logic [DW-1:0] w);
    txq.push_back(w);
    exp_txq.push_back(w);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    usb_tx_full           = force_full || ($urandom_range(99) < full_pct);
    periph_data_available = (txq.size() > 0) && !($urandom_range(99) < gap_pct);
    periph_data           = (txq.size() > 0) ? txq[0] : $urandom;
    usb_rx_empty          = (rxq.size() == 0) || ($urandom_range(99) < stall_pct);
    usb_data_in           = (rxq.size() > 0) ? rxq[0].d : $urandom;
    usb_be_in             = (rxq.size() > 0) ? rxq[0].be : BW'($urandom);
    rx_afull              = ($urandom_range(99) < afull_pct);
  end

  // Phase model and observed-traffic records.
  int            m_ph = P_RESET, m_rc = 0, m_cnt = 0;
  bit            m_last_rd = 1'b0, m_rxv = 1'b0;
  logic [DW-1:0] m_rxd = '0;
  logic [BW-1:0] m_rxbe = '0;
  logic [31:0]   m_stx = '0, m_srx = '0;
  logic [15:0]   m_sb = '0;
  bit            chk_en = 1'b0;
  int            bursts_q[$];          // rd bursts as 1000+len, wr bursts as len
  logic [DW-1:0] wr_seen[$], rx_seen[$];
  int rst_low_cnt = 0, tx_pops = 0, rxv_cnt = 0, wr_run = 0, wr_run_max = 0;

  always @(negedge clk) begin
    bit wr, cap, rd_req, wr_req;
    wr  = (m_ph == P_WR) && periph_data_available && !usb_tx_full && (m_cnt < MB);
    cap = (m_ph == P_RD) && !usb_rx_empty;
    if (chk_en) begin
      chk("usb_rst_l", usb_rst_l, m_ph != P_RESET);
      chk("strobes {outen,rden,wren,pop,dir}",
          {usb_outen_l, usb_rden_l, usb_wren_l, read_periph_data, ft601_data_bus_dir},
          {!(m_ph == P_RDOE || m_ph == P_RD), m_ph != P_RD, !wr, wr, m_ph == P_WR});
      chk("dir_with_outen", ft601_data_bus_dir && !usb_outen_l, 1'b0);
      chk("usb_be_out", usb_be_out, 4'hF);
      chk("rx_valid", rx_valid, m_rxv);
      chk("rx_data", rx_data, m_rxd);
      chk("rx_be", rx_be, m_rxbe);
      if (wr) begin
        if (exp_txq.size() > 0) chk("usb_data_out", usb_data_out, exp_txq[0]);
        else chk("tx_model_underflow", 1'b1, 1'b0);
      end
`ifdef FT60X_STATS_EN
      chk("stat_tx_words", stat_tx_words, m_stx);
      chk("stat_rx_words", stat_rx_words, m_srx);
      chk("stat_bursts", stat_bursts, m_sb);
`endif
      if (!rst && !usb_rst_l) rst_low_cnt++;
    end
    // Environment reacts to the DUT's own strobes.
    if (read_periph_data && txq.size() > 0) begin
      void'(txq.pop_front());
      tx_pops++;
    end
    if (!usb_rden_l && !usb_rx_empty && rxq.size() > 0) void'(rxq.pop_front());
    if (!usb_wren_l) begin
      wr_seen.push_back(usb_data_out);
      wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
    end else wr_run = 0;
    if (rx_valid) begin
      rx_seen.push_back(rx_data);
      rxv_cnt++;
    end
    // Advance the model by one cycle.
    rd_req = !usb_rx_empty && !rx_afull;
    wr_req = periph_data_available && !usb_tx_full;
    m_rxv = cap;
    if (cap) begin
      m_rxd  = usb_data_in;
      m_rxbe = usb_be_in;
      m_srx++;
    end
    if (wr) begin
      if (exp_txq.size() > 0) void'(exp_txq.pop_front());
      m_stx++;
    end
    case (m_ph)
      P_RESET: if (m_rc == RC - 1) m_ph = P_IDLE; else m_rc++;
      P_IDLE: begin
        m_cnt = 0;
        if (rd_req && (!wr_req || !m_last_rd)) begin m_ph = P_RDOE; m_last_rd = 1'b1; end
        else if (wr_req) begin m_ph = P_WR; m_last_rd = 1'b0; end
      end
      P_RDOE: m_ph = P_RD;
      P_RD: begin
        if (cap) m_cnt++;
        if (usb_rx_empty || rx_afull || m_cnt == MB) begin
          bursts_q.push_back(1000 + m_cnt);
          m_ph = P_RDEND;
        end
      end
      P_RDEND: begin m_ph = P_TURN; m_sb++; end
      P_WR: begin
        if (wr) m_cnt++;
        else begin
          bursts_q.push_back(m_cnt);
          m_ph = P_TURN;
          m_sb++;
        end
      end
      default: m_ph = P_IDLE;
    endcase
    if (rst) begin
      m_ph = P_RESET; m_rc = 0; m_cnt = 0; m_last_rd = 1'b0;
      m_rxv = 1'b0; m_rxd = '0; m_rxbe = '0; m_stx = '0; m_srx = '0; m_sb = '0;
    end
  end

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while (!(m_ph == P_IDLE && txq.size() == 0 && rxq.size() == 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_records();
    bursts_q.delete(); wr_seen.delete(); rx_seen.delete();
    tx_pops = 0; rxv_cnt = 0; wr_run_max = 0;
  endtask

  task automatic do_reset();
    int n = 0;
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; rst_low_cnt = 0;
    while (usb_rst_l !== 1'b1 && n < 100) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("rst_low_cycles", rst_low_cnt, RC);
  endtask

  logic [DW-1:0] ref_w[$];
  logic [DW-1:0] w;
  int snap;

  initial begin
    @(posedge clk); #1; chk_en = 1'b1;
    // Reset release: usb_rst_l low for exactly RC cycles.
    do_reset();

    // Both directions pending from a fresh reset: RD wins first, then alternate.
    clear_records();
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      push_tx(32'hA000_0000 + i);
      rxq.push_back('{d: 32'hB000_0000 + i, be: 4'(i)});
    end
    wait_quiet(1000, "both");
    chk("alt_nbursts", bursts_q.size(), 6);
    if (bursts_q.size() >= 4) begin
      chk("alt_b0", bursts_q[0], 1000 + MB);
      chk("alt_b1", bursts_q[1], MB);
      chk("alt_b2", bursts_q[2], 1000 + MB);
      chk("alt_b3", bursts_q[3], MB);
    end
    chk("alt_rx_count", rx_seen.size(), 40);
    if (rx_seen.size() == 40) chk("alt_rx_last", rx_seen[39], 32'hB000_0027);

    // Ten words TX only.
    clear_records();
    ref_w.delete();
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      ref_w.push_back(w);
      push_tx(w);
    end
    wait_quiet(200, "tx10");
    chk("tx10_pops", tx_pops, 10);
    chk("tx10_wren_run", wr_run_max, 10);
    chk("tx10_bursts", bursts_q.size(), 1);
    chk("tx10_nwritten", wr_seen.size(), 10);
    for (int i = 0; i < 10 && i < wr_seen.size(); i++) chk("tx10_order", wr_seen[i], ref_w[i]);

    // Forty words RX only: bursts of MB, MB, then the rest.
    clear_records();
    ref_w.delete();
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      ref_w.push_back(w);
      rxq.push_back('{d: w, be: 4'hF});
    end
    wait_quiet(400, "rx40");
    chk("rx40_nbursts", bursts_q.size(), 3);
    if (bursts_q.size() == 3) begin
      chk("rx40_b0", bursts_q[0], 1000 + MB);
      chk("rx40_b1", bursts_q[1], 1000 + MB);
      chk("rx40_b2", bursts_q[2], 1000 + 40 - 2 * MB);
    end
    chk("rx40_count", rx_seen.size(), 40);
    for (int i = 0; i < 40 && i < rx_seen.size(); i++) chk("rx40_order", rx_seen[i], ref_w[i]);

    // TX FIFO fills after the third of eight words.
    clear_records();
    @(posedge clk);
    for (int i = 0; i < 8; i++) push_tx(32'hC000_0000 + i);
    snap = 0;
    do begin @(posedge clk); snap++; end while (tx_pops < 3 && snap < 100);
    force_full = 1'b1;
    repeat (4) @(posedge clk);
    force_full = 1'b0;
    wait_quiet(200, "txfull");
    chk("txfull_nbursts", bursts_q.size(), 2);
    if (bursts_q.size() == 2) begin
      chk("txfull_b0", bursts_q[0], 3);
      chk("txfull_b1", bursts_q[1], 5);
    end
    chk("txfull_nwritten", wr_seen.size(), 8);

    // Reset in the middle of a read burst.
    clear_records();
    @(posedge clk);
    for (int i = 0; i < 40; i++) rxq.push_back('{d: 32'hD000_0000 + i, be: 4'h3});
    snap = 0;
    do begin @(posedge clk); snap++; end while (!(m_ph == P_RD && m_cnt >= 5) && snap < 100);
    #1; rst = 1'b1;
    @(posedge clk);
    snap = rxv_cnt;
    @(negedge clk);
    chk("midrst_rden_l", usb_rden_l, 1'b1);
    chk("midrst_outen_l", usb_outen_l, 1'b1);
    chk("midrst_rst_l", usb_rst_l, 1'b0);
`ifdef FT60X_STATS_EN
    chk("midrst_stat_rx", stat_rx_words, 32'd0);
    chk("midrst_stat_bursts", stat_bursts, 16'd0);
`endif
    repeat (3) @(posedge clk);
    chk("midrst_no_rx_valid", rxv_cnt, snap);
    rxq.delete();
    #1; rst = 1'b0;
    wait_quiet(200, "midrst");

    // Randomized traffic with back-pressure and one reset pulse.
    for (int r = 0; r < 15; r++) begin
      full_pct  = $urandom_range(40);
      stall_pct = $urandom_range(40);
      afull_pct = $urandom_range(30);
      gap_pct   = $urandom_range(30);
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        if (txq.size() < 12 && $urandom_range(3) == 0) push_tx($urandom);
        if (rxq.size() < 12 && $urandom_range(3) == 0)
          rxq.push_back('{d: $urandom, be: 4'($urandom)});
        if (r == 7 && c == 100) begin #1; rst = 1'b1; end
        if (r == 7 && c == 103) begin #1; rst = 1'b0; end
      end
    end
    full_pct = 0; stall_pct = 0; afull_pct = 0; gap_pct = 0;
    wait_quiet(3000, "random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
